// File: rtl/galaga_pkg.sv
// ============================================================================
// galaga_pkg : shared types and defaults for the enemy death sequence
// Rev 1.0
// ============================================================================
`default_nettype none

package galaga_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    DEAD    = 2'd2
  } death_state_t;

  localparam int              FRAMES_PER_SPRITE_DEF = 4;
  localparam int              NUM_SPRITES_DEF       = 4;
  localparam int              RESPAWN_FRAMES_DEF    = 60;
  localparam int              SCORE_W               = 16;
  localparam int              CNT_W                 = 8;
  localparam logic [SCORE_W-1:0] POINTS_DEF         = 16'd50;

  // Saturating score add: a kill never wraps the score back to a small value.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_counter.sv
// ============================================================================
// frame_counter : 8-bit frame-tick counter with clear and terminal compare
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_counter
  import galaga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  // expired marks the tick that lands on the terminal value; the count wraps there
  always_comb begin
    expired = en && (count_q == terminal);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (expired) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_death_sequencer.sv
// ============================================================================
// enemy_death_sequencer : acknowledges an enemy hit, steps the explosion
// sprites, holds the ship dead, then respawns. Optional macro: ENEMY_SCORE_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module enemy_death_sequencer
  import galaga_pkg::*;
#(
  parameter int                 FRAMES_PER_SPRITE = FRAMES_PER_SPRITE_DEF,
  parameter int                 NUM_SPRITES       = NUM_SPRITES_DEF,
  parameter int                 RESPAWN_FRAMES    = RESPAWN_FRAMES_DEF,
  parameter logic [SCORE_W-1:0] POINTS            = POINTS_DEF
)
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               enemy_hit,
  output logic               done,
  output logic               ship_alive,
  output logic               explosion_active,
  output logic [1:0]         explosion_frame,
  output logic               respawn,
  output logic [SCORE_W-1:0] score
);

  localparam logic [CNT_W-1:0] EXPL_TERM   = CNT_W'(FRAMES_PER_SPRITE - 1);
  localparam logic [CNT_W-1:0] DEAD_TERM   = (RESPAWN_FRAMES == 0) ? '0
                                             : CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [1:0]       LAST_SPRITE = 2'(NUM_SPRITES - 1);

  death_state_t     state_q, state_d;
  logic [1:0]       frame_q, frame_d;
  logic             done_q, done_d;
  logic             alive_q, alive_d;
  logic             active_q, active_d;
  logic             respawn_q, respawn_d;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_expired;

  frame_counter u_frame_counter (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clr      (cnt_clr),
    .en       (frame_tick),
    .terminal (cnt_term),
    .expired  (cnt_expired)
  );

  // The counter is held clear in ALIVE, so a tick coincident with the hit is dropped
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    cnt_clr  = 1'b0;
    cnt_term = EXPL_TERM;
    case (state_q)
      ALIVE: begin
        cnt_clr = 1'b1;
        frame_d = '0;
        if (enemy_hit) begin
          state_d = EXPLODE;
        end
      end
      EXPLODE: begin
        if (cnt_expired) begin
          if (frame_q == LAST_SPRITE) begin
            cnt_clr = 1'b1;
            frame_d = '0;
            state_d = (RESPAWN_FRAMES == 0) ? ALIVE : DEAD;
          end else begin
            frame_d = frame_q + 2'd1;
          end
        end
      end
      DEAD: begin
        cnt_term = DEAD_TERM;
        if (cnt_expired) begin
          cnt_clr = 1'b1;
          state_d = ALIVE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        frame_d = '0;
        state_d = ALIVE;
      end
    endcase

    done_d    = (state_d != ALIVE);
    alive_d   = (state_d == ALIVE);
    active_d  = (state_d == EXPLODE);
    respawn_d = (state_q != ALIVE) && (state_d == ALIVE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ALIVE;
      frame_q   <= '0;
      done_q    <= 1'b0;
      alive_q   <= 1'b1;
      active_q  <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      alive_q   <= alive_d;
      active_q  <= active_d;
      respawn_q <= respawn_d;
    end
  end

  assign done             = done_q;
  assign ship_alive       = alive_q;
  assign explosion_active = active_q;
  assign explosion_frame  = frame_q;
  assign respawn          = respawn_q;

`ifdef ENEMY_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if ((state_q == ALIVE) && enemy_hit) begin
      score_d = sat_add(score_q, POINTS);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  logic unused_points;
  assign unused_points = ^POINTS;
  assign score         = '0;
`endif

endmodule

`default_nettype wire
